// File: rtl/universal_shift_reg.sv
// Universal shift register with a multi-step IDLE/RUN/DONE sequencer.
// A start in IDLE latches an operation (mode) and step count (amt, clamped to N).
// Parallel load, hold and zero-length requests complete immediately.
// Shift and rotate requests step once per enabled clock while in RUN.
//
// Ports:
//   clk, rst          - clock; synchronous active-high reset
//   en                - step enable for RUN (low pauses the operation)
//   start             - operation request, sampled only in IDLE
//   mode[2:0]         - operation select, latched on start
//   amt[AW-1:0]       - number of single-bit steps, latched on start
//   d[N-1:0]          - parallel load data
//   sin_lsb, sin_msb  - serial inputs for logical left / right shifts
//   Q[N-1:0]          - register contents
//   sout_msb/sout_lsb - combinational copies of Q[N-1] / Q[0]
//   busy              - high while in RUN
//   done              - one-cycle completion pulse
module universal_shift_reg #(
  parameter int unsigned N = 4,
  localparam int unsigned AW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [AW-1:0] amt,
  input  logic [N-1:0]  d,
  input  logic          sin_lsb,
  input  logic          sin_msb,
  output logic [N-1:0]  Q,
  output logic          sout_msb,
  output logic          sout_lsb,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_ROL  = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ASR  = 3'b101;
  localparam logic [2:0] M_LOAD = 3'b110;
  localparam logic [2:0] M_RSVD = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [2:0]    mode_q, mode_d;
  logic [N-1:0]  q_d;
  logic          busy_d, done_d;
  logic [AW-1:0] amt_clamped;

  // One single-bit step of the selected operation.
  function automatic logic [N-1:0] step_fn(input logic [2:0] m, input logic [N-1:0] q,
                                           input logic sl, input logic sm);
    logic [N-1:0] r;
    r = q;
    case (m)
      M_SHL:   r = {q[N-2:0], sl};
      M_SHR:   r = {sm, q[N-1:1]};
      M_ROL:   r = {q[N-2:0], q[N-1]};
      M_ROR:   r = {q[0], q[N-1:1]};
      M_ASR:   r = {q[N-1], q[N-1:1]};
      default: r = q;
    endcase
    return r;
  endfunction

  assign amt_clamped = (amt > AW'(N)) ? AW'(N) : amt;

  assign sout_msb = Q[N-1];
  assign sout_lsb = Q[0];

  // Next-state, counter, data and flag logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    q_d     = Q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d = mode;
          if (mode == M_LOAD) begin
            q_d     = d;
            cnt_d   = '0;
            state_d = DONE;
          end else if (mode == M_HOLD || mode == M_RSVD || amt_clamped == '0) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d   = amt_clamped;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // Counter is never zero in RUN; the step taken at count 1 is the last.
        if (en) begin
          q_d   = step_fn(mode_q, Q, sin_lsb, sin_msb);
          cnt_d = cnt_q - AW'(1);
          if (cnt_q == AW'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= M_HOLD;
      Q       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      Q       <= q_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 The block SHALL have one parameter: N, default 4, register width in bits (N >= 2).
REQ-002 The block SHALL have one derived localparam: AW = $clog2(N+1), width of the shift-amount field.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have the port en, input, 1 bit: step enable; while low, any RUN operation pauses.
REQ-006 The block SHALL have the port start, input, 1 bit: request to begin an operation; sampled only in IDLE.
REQ-007 The block SHALL have the port mode, input, 3 bits: operation select, latched on start.
REQ-008 The block SHALL have the port amt, input, AW bits: number of single-bit steps, latched on start.
REQ-009 The block SHALL have the port d, input, N bits: parallel load data.
REQ-010 The block SHALL have the port sin_lsb, input, 1 bit: serial bit entering at Q[0] on a left shift; sampled live at each step.
REQ-011 The block SHALL have the port sin_msb, input, 1 bit: serial bit entering at Q[N-1] on a logical right shift; sampled live at each step.
REQ-012 The block SHALL have the port Q, output, N bits: register contents.
REQ-013 The block SHALL have the port sout_msb, output, 1 bit: combinational copy of Q[N-1].
REQ-014 The block SHALL have the port sout_lsb, output, 1 bit: combinational copy of Q[0].
REQ-015 The block SHALL have the port busy, output, 1 bit: high while in RUN.
REQ-016 The block SHALL have the port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-017 The block SHALL decode mode as follows:
- 000: hold
- 001: shift left (Q <= {Q[N-2:0], sin_lsb})
- 010: shift right (Q <= {sin_msb, Q[N-1:1]})
- 011: rotate left
- 100: rotate right
- 101: arithmetic shift right (MSB replicated)
- 110: parallel load
- 111: reserved, behaves as hold
REQ-018 The block SHALL implement FSM states IDLE, RUN and DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-019 In IDLE with start=1, the block SHALL latch mode and amt, clamped to N if amt > N.
REQ-020 On that start edge, if mode is load, the block SHALL set Q<=d and go to DONE, independent of en.
REQ-021 On that start edge, if mode is hold/reserved or amt==0, the block SHALL leave Q unchanged and go to DONE.
REQ-022 On that start edge, for any other mode, the block SHALL go to RUN with step counter = amt.
REQ-023 In RUN, each rising edge with en=1 SHALL perform exactly one single-bit step of the latched mode and decrement the counter.
REQ-024 The edge performing the final step SHALL move the FSM to DONE.
REQ-025 In RUN with en=0, Q, the counter and the state SHALL hold, and busy SHALL remain 1.
REQ-026 DONE SHALL last exactly one cycle, then return to IDLE; with en held high, done is high in the cycle following the (amt)th step edge.
REQ-027 start while in RUN or DONE SHALL be ignored, with no queuing.
REQ-028 mode, amt and d changes after the start edge SHALL have no effect on the running operation.
REQ-029 Q SHALL hold in IDLE and DONE.
REQ-030 sout_msb and sout_lsb SHALL track Q combinationally at all times.

Reset
REQ-031 When rst=1 at a rising edge, the block SHALL set Q=0, busy=0, done=0, FSM=IDLE and counter=0, overriding start and en.
REQ-032 Reset asserted mid-RUN SHALL abort the operation, with no done pulse generated.
REQ-033 The block SHALL accept the first start on the first edge after rst deasserts.

Verification (N=4)
REQ-034 The bench SHALL cover reset: hold rst high 2 cycles with start=1, mode=110, d=1111 -> Q=0000, busy=0, done=0.
REQ-035 The bench SHALL cover parallel load: start with mode=110, d=1011 -> Q=1011 after the start edge, done=1 for exactly the next cycle, busy never high.
REQ-036 The bench SHALL cover rotate left: from Q=1011, start with mode=011, amt=2, en=1 -> Q=0111 then 1110, busy high 2 cycles, done pulse follows; a start issued during busy is ignored.
REQ-037 The bench SHALL cover arithmetic shift right: from Q=1000, mode=101, amt=3 -> 1100, 1110, 1111; a follow-up with amt=7 is clamped to 4 steps.
REQ-038 The bench SHALL cover pause: mode=001, amt=2, sin_lsb=1, from Q=0000, en low for 1 cycle between the two steps -> Q=0001, hold, 0011; done arrives one cycle later than with en held high.
REQ-039 The bench SHALL cover abort and edge cases: rst pulsed in the second RUN cycle of an amt=4 shift -> Q=0000, IDLE, no done; and amt=0 with mode=001 -> Q unchanged, done pulse next cycle.
